// File: rtl/bus_synchronizer.sv
// Multi-flop synchronizer for a gray-coded bus crossing into the clk domain.
// Each bit runs through an identical STAGE_COUNT-deep flop chain; no cross-bit logic.
module bus_synchronizer #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic [BUS_WIDTH-1:0] synchronous_data
);

  if (STAGE_COUNT < 2) begin : g_bad_stage_count
    $error("bus_synchronizer: STAGE_COUNT must be >= 2");
  end
  if (BUS_WIDTH < 1) begin : g_bad_bus_width
    $error("bus_synchronizer: BUS_WIDTH must be >= 1");
  end

  // Stage registers are marked as synchronizer cells so tools keep them adjacent and unretimed.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [BUS_WIDTH-1:0] r_stage [STAGE_COUNT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGE_COUNT; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= asynchronous_data;
      for (int k = 1; k < STAGE_COUNT; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign synchronous_data = r_stage[STAGE_COUNT-1];

endmodule

// File: tb/tb_bus_synchronizer.sv
// Directed bench for bus_synchronizer: default 2x4 instance plus a 3-stage, 8-bit instance.
// Expected values are queued when the input changes and popped when the output is due.
module tb_bus_synchronizer;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic [3:0] din;
  logic [3:0] dout;
  logic [7:0] din8;
  logic [7:0] dout8;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  bus_synchronizer #(.STAGE_COUNT(2), .BUS_WIDTH(4)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .asynchronous_data (din),
    .synchronous_data  (dout)
  );

  bus_synchronizer #(.STAGE_COUNT(3), .BUS_WIDTH(8)) u_dut8 (
    .clk               (clk),
    .reset             (reset),
    .asynchronous_data (din8),
    .synchronous_data  (dout8)
  );

  // clock/reset block: 12-unit destination period, rising edges at 6 + 12k
  initial begin
    clk = 1'b0;
    forever #6 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] gray [15] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111,
                            4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    logic [3:0] prev;
    longint     t0;

    // reset with all-ones input: output cleared before any clock edge
    reset = 1'b1;
    din   = 4'hF;
    din8  = 8'hFF;
    #1;
    check("rst_immediate", {4'h0, dout}, 8'h00);
    check("rst_immediate8", dout8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check("rst_held", {4'h0, dout}, 8'h00);
      check("rst_held8", dout8, 8'h00);
    end

    @(negedge clk);
    din   = 4'h0;
    din8  = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // gray sweep: source changes every 30 units, off the destination edges
    prev = 4'h0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 15; i++) begin
      t0  = $time;
      din = gray[i];
      exp_q.push_back({4'h0, gray[i]});
      edge_sample();
      check("gray_edge1_old", {4'h0, dout}, {4'h0, prev});
      edge_sample();
      check("gray_edge2_new", {4'h0, dout}, exp_q.pop_front());
      prev = gray[i];
      #(30 - ($time - t0));
    end

    // mid-operation reset with 1100 in flight behind 0100
    @(posedge clk);
    #2;
    din = 4'b0100;
    repeat (3) @(posedge clk);
    #2;
    din = 4'b1100;
    edge_sample();
    check("inflight_out", {4'h0, dout}, 8'h04);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_immediate", {4'h0, dout}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h0C);
    edge_sample();
    check("post_rst_edge1", {4'h0, dout}, 8'h00);
    edge_sample();
    check("post_rst_edge2", {4'h0, dout}, exp_q.pop_front());

    // 3-stage, 8-bit instance: 0x00 -> 0x80 needs exactly three edges
    @(posedge clk);
    #2;
    din8 = 8'h80;
    exp_q.push_back(8'h80);
    edge_sample();
    check("wide_edge1", dout8, 8'h00);
    edge_sample();
    check("wide_edge2", dout8, 8'h00);
    edge_sample();
    check("wide_edge3", dout8, exp_q.pop_front());

    // held input must give a constant output
    @(posedge clk);
    #2;
    din = 4'b1010;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stable_1010", {4'h0, dout}, 8'h0A);
      check("stable_wide", dout8, 8'h80);
    end

    check("queue_drained", W'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
